// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits). It rejects false starts, flags parity and
// framing errors on each frame, and detects a break.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over mid-1, mid and mid+1, taken at mid+1. All latencies grow
// by one clock.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | line idle, waiting for a 1->0 edge on the synced line
// S_START     | timing to the middle of the start bit, rejecting glitches
// S_DATA      | sampling NUM_DATA_BITS data bits, LSB first
// S_PARITY    | sampling the parity bit (only when PARITY_MODE != 0)
// S_STOP      | sampling stop bits; the last one publishes the frame
// S_WAIT_HIGH | last stop bit was 0; ignore the line until it reads 1

module uart_rx_cfg #(
  parameter int CLKS_PER_BIT  = 217,
  parameter int NUM_DATA_BITS = 8,
  parameter int PARITY_MODE   = 0,
  parameter int NUM_STOP_BITS = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_rx,
  output logic [NUM_DATA_BITS-1:0] o_rxData,
  output logic                     o_rxStrobe,
  output logic                     o_parityError,
  output logic                     o_frameError,
  output logic                     o_breakDetect
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_TICK = CNT_W'(CLKS_PER_BIT / 2 + 1);
`else
  localparam logic [CNT_W-1:0] START_TICK = CNT_W'(CLKS_PER_BIT / 2);
`endif
  localparam logic [3:0] DATA_LAST = 4'(NUM_DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(NUM_STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY_MODE == 1);

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (NUM_DATA_BITS < 5 || NUM_DATA_BITS > 9) begin : g_bad_width
    $error("uart_rx_cfg: NUM_DATA_BITS must be 5..9");
  end
  if (NUM_STOP_BITS < 1 || NUM_STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_cfg: NUM_STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be at least 8");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                   state_q, state_d;
  logic                     sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               bit_q, bit_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                     par_q, par_d, frm_q, frm_d, zero_q, zero_d;
  logic                     perr_q, perr_d, ferr_q, ferr_d;
  logic                     strobe_q, strobe_d, brk_q, brk_d;
  logic                     samp, tick, frm_now, zero_now;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds the synced line one cycle ago, hist_q[1] two cycles ago
  logic [1:0] hist_q, hist_d;
  assign samp = (hist_q[0] & hist_q[1]) | (hist_q[0] & sync2_q) | (hist_q[1] & sync2_q);
`else
  assign samp = sync2_q;
`endif

  // START times a half bit; every later state times a full bit
  assign tick     = (state_q == S_START) ? (cnt_q == START_TICK) : (cnt_q == CNT_LAST);
  assign frm_now  = frm_q | ~samp;
  assign zero_now = zero_q & ~samp;

  // next-state and datapath decode
  always_comb begin
    sync1_d  = i_rx;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
`ifdef UART_RX_MAJORITY_EN
    hist_d   = {hist_q[0], sync2_q};
`endif
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    frm_d    = frm_q;
    zero_d   = zero_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    strobe_d = 1'b0;
    brk_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          state_d = S_START;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d = '0;
          if (samp) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            zero_d  = 1'b1;
            frm_d   = 1'b0;
            par_d   = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {samp, shift_q[NUM_DATA_BITS-1:1]};
          zero_d  = zero_now;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          zero_d  = zero_now;
          par_d   = ((^shift_q) ^ samp) != PAR_ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          frm_d  = frm_now;
          zero_d = zero_now;
          if (bit_q == STOP_LAST) begin
            bit_d    = '0;
            data_d   = shift_q;
            perr_d   = par_q;
            ferr_d   = frm_now;
            brk_d    = zero_now;
            strobe_d = 1'b1;
            state_d  = samp ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // all state registers, synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q   <= 2'b11;
`endif
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      frm_q    <= 1'b0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      strobe_q <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q   <= hist_d;
`endif
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      frm_q    <= frm_d;
      zero_q   <= zero_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      strobe_q <= strobe_d;
      brk_q    <= brk_d;
    end
  end

  assign o_rxData      = data_q;
  assign o_rxStrobe    = strobe_q;
  assign o_parityError = perr_q;
  assign o_frameError  = ferr_q;
  assign o_breakDetect = brk_q;

endmodule
